// File: rtl/timer_pkg.sv
// Shared types for the round timer: the controller's state encoding.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer_ctrl_tick_gen.sv
// Prescaler for the round timer: counts 0..TICK_DIV-1 while enabled and
// flags the terminal count so the controller can act on the following edge.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic iclr,
    input  logic ien,
    output logic owrap
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign owrap = ien && (cnt == LAST);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            cnt <= '0;
        end else if (iclr) begin
            cnt <= '0;
        end else if (ien) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Round timer controller: start/pause/stop command FSM, countdown register,
// expiry pulse and the expired-state blink output, all registered.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 8
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istart,
    input  logic             ipause,
    input  logic             istop,
    input  logic [CNT_W-1:0] iload_val,
    output logic [1:0]       ostate,
    output logic [CNT_W-1:0] oremaining,
    output logic             otick,
    output logic             oexpired,
    output logic             oblink
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   rem_n;
    logic               tick_n, exp_n, blink_n;
    logic               pre_clr, pre_en, wrap;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iclr   (pre_clr),
        .ien    (pre_en),
        .owrap  (wrap)
    );

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state      <= IDLE;
            oremaining <= '0;
            otick      <= 1'b0;
            oexpired   <= 1'b0;
            oblink     <= 1'b0;
        end else begin
            state      <= state_n;
            oremaining <= rem_n;
            otick      <= tick_n;
            oexpired   <= exp_n;
            oblink     <= blink_n;
        end
    end

    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        rem_n   = oremaining;
        tick_n  = 1'b0;
        exp_n   = 1'b0;
        blink_n = (state == EXPIRED) ? oblink : 1'b0;
        pre_clr = 1'b0;
        pre_en  = (state == RUN) || (state == EXPIRED);

        if (istop) begin
            state_n = IDLE;
            pre_clr = 1'b1;
            blink_n = 1'b0;
        end else if (istart) begin
            pre_clr = 1'b1;
            blink_n = 1'b0;
            rem_n   = iload_val;
            if (iload_val == '0) begin
                state_n = EXPIRED;
                exp_n   = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (wrap) begin
                        tick_n = 1'b1;
                        if (oremaining != '0) rem_n = oremaining - 1'b1;
                        // A tick that coincides with ipause is still counted.
                        if (oremaining <= 1) begin
                            exp_n   = 1'b1;
                            state_n = EXPIRED;
                        end else if (ipause) begin
                            state_n = PAUSED;
                        end
                    end else if (ipause) begin
                        state_n = PAUSED;
                    end
                end
                PAUSED: begin
                    if (ipause) state_n = RUN;
                end
                EXPIRED: begin
                    if (wrap) blink_n = ~oblink;
                end
                default: ;
            endcase
        end
    end

    assign ostate = state;

endmodule
